freq_stream_packer: RTL and testbench

//  AXI-Stream receiver for the selected-channel stream from the frequency selector
//  (80b tdata, 53b tuser, tlast). Buffers samples in a FIFO and re-emits each one as

---
 rtl/freq_stream_packer.sv | 143 ++++++++++++++
 tb/tb_freq_stream_packer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_stream_packer.sv
// Buffers 80b samples with 53b sideband in a 16-deep FIFO.
// Each sample is re-emitted as five 32-bit AXI-Stream words for DMA.
module freq_stream_packer #(
  parameter int         FIFO_AW     = 4,
  parameter logic [3:0] SYNC_NIBBLE = 4'hA
) (
  input  logic        dev_clk,
  input  logic        dev_rst,
  input  logic [79:0] s_axis_tdata,
  input  logic [52:0] s_axis_tuser,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [15:0] overflow_count,
  output logic [31:0] frame_count,
  output logic        busy
);

  localparam int EW = 134;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  logic [EW-1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   fifo_count;
  logic [EW-1:0]      head;
  logic [EW-1:0]      hold;
  logic [2:0]         widx;
  state_t             state;

  logic push, drop, pop, m_hs, fifo_nonempty, last_word;

  // Handshake rule on both ports: a transfer happens on a rising edge where
  // valid and ready are both high; a master holds data/last stable while
  // valid is high and ready is low, and never withdraws valid mid-sample.
  assign s_axis_tready = !dev_rst && (fifo_count != FULL_COUNT);
  assign push          = s_axis_tvalid && s_axis_tready;
  assign drop          = s_axis_tvalid && !s_axis_tready;
  assign fifo_nonempty = (fifo_count != '0);
  assign m_hs          = m_axis_tvalid && m_axis_tready;
  assign last_word     = (widx == 3'd4);
  assign pop           = fifo_nonempty &&
                         ((state == IDLE) || ((state == SEND) && m_hs && last_word));
  assign head          = mem[rd_ptr];
  assign busy          = (state != IDLE) || fifo_nonempty;

  // Entry layout: [133] tlast, [132:101] ts, [100:94] index, [93:80] k, [79:0] tdata.
  function automatic logic [31:0] word_of(input logic [EW-1:0] e, input logic [2:0] w);
    logic [31:0] r;
    r = '0;
    case (w)
      3'd0:    r = e[132:101];
      3'd1:    r = {SYNC_NIBBLE, 1'b0, e[100:94], 6'b0, e[93:80]};
      3'd2:    r = e[31:0];
      3'd3:    r = e[63:32];
      default: r = {16'h0, e[79:64]};
    endcase
    return r;
  endfunction

  always_ff @(posedge dev_clk) begin
    if (push) begin
      mem[wr_ptr] <= {s_axis_tlast, s_axis_tuser, s_axis_tdata};
    end
  end

  always_ff @(posedge dev_clk) begin
    if (dev_rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count     <= '0;
      overflow_count <= '0;
      frame_count    <= '0;
      hold           <= '0;
      widx           <= '0;
      state          <= IDLE;
      m_axis_tdata   <= '0;
      m_axis_tvalid  <= 1'b0;
      m_axis_tlast   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase

      if (drop && (overflow_count != 16'hFFFF)) begin
        overflow_count <= overflow_count + 16'd1;
      end

      if (m_hs && m_axis_tlast) begin
        frame_count <= frame_count + 32'd1;
      end

      case (state)
        IDLE: begin
          if (pop) begin
            hold          <= head;
            widx          <= 3'd0;
            m_axis_tdata  <= word_of(head, 3'd0);
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b1;
            state         <= SEND;
          end
        end
        SEND: begin
          if (m_hs) begin
            if (last_word) begin
              // Chain straight into the next queued sample so there is no bubble.
              if (pop) begin
                hold          <= head;
                widx          <= 3'd0;
                m_axis_tdata  <= word_of(head, 3'd0);
                m_axis_tlast  <= 1'b0;
                m_axis_tvalid <= 1'b1;
              end else begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                state         <= IDLE;
              end
            end else begin
              widx         <= widx + 3'd1;
              m_axis_tdata <= word_of(hold, widx + 3'd1);
              m_axis_tlast <= (widx == 3'd3) && hold[EW-1];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_stream_packer.sv
// Directed bench for freq_stream_packer: scoreboard of expected output words,
// stall-stability monitor and checks of counters, latency and reset.
`timescale 1ns/1ps
module tb_freq_stream_packer;

  logic        dev_clk = 1'b0;
  logic        dev_rst;
  logic [79:0] s_axis_tdata;
  logic [52:0] s_axis_tuser;
  logic        s_axis_tlast;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [15:0] overflow_count;
  logic [31:0] frame_count;
  logic        busy;

  freq_stream_packer dut (
    .dev_clk(dev_clk), .dev_rst(dev_rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
    .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .overflow_count(overflow_count), .frame_count(frame_count), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 dev_clk = ~dev_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];
  logic [32:0] got_log[$];
  int          hs_cyc[$];
  int          cyc = 0;
  int          words_seen = 0;
  int          exp_frames = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] exp_word(input logic [79:0] d, input logic [31:0] ts,
                                           input logic [6:0] idx, input logic [13:0] k,
                                           input logic last, input int w);
    case (w)
      0:       return {1'b0, ts};
      1:       return {1'b0, 4'hA, 1'b0, idx, 6'b0, k};
      2:       return {1'b0, d[31:0]};
      3:       return {1'b0, d[63:32]};
      default: return {last, 16'h0, d[79:64]};
    endcase
  endfunction

  // ---------------- monitor ----------------
  always @(negedge dev_clk) begin
    logic [32:0] e;
    cyc++;
    if (dev_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", m_axis_tvalid, 1'b1);
        check("stall_data", m_axis_tdata, prev_data);
        check("stall_last", m_axis_tlast, prev_last);
      end
      if ((words_seen % 5) != 0) check("mid_sample_valid", m_axis_tvalid, 1'b1);
      if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {m_axis_tlast, m_axis_tdata}, 33'h1_dead_0000);
        end else begin
          e = exp_q.pop_front();
          check("word", {m_axis_tlast, m_axis_tdata}, e);
        end
        got_log.push_back({m_axis_tlast, m_axis_tdata});
        hs_cyc.push_back(cyc);
        words_seen++;
      end
      prev_stall = (m_axis_tvalid === 1'b1) && (m_axis_tready !== 1'b1);
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_sample(input logic [79:0] d, input logic [31:0] ts,
                              input logic [6:0] idx, input logic [13:0] k,
                              input logic last, input logic exp_accept);
    s_axis_tdata  = d;
    s_axis_tuser  = {ts, idx, k};
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    @(negedge dev_clk);
    check("s_tready", s_axis_tready, exp_accept);
    if (exp_accept) begin
      for (int w = 0; w < 5; w++) exp_q.push_back(exp_word(d, ts, idx, k, last, w));
      if (last) exp_frames++;
    end
    @(posedge dev_clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drive_rand(input logic last, input logic exp_accept);
    logic [79:0] d;
    d = {16'($urandom), $urandom, $urandom};
    drive_sample(d, $urandom, 7'($urandom_range(0, 127)),
                 14'($urandom_range(0, 16383)), last, exp_accept);
  endtask

  // mode 0: ready held high; mode 1: ready toggles 1,0,1,0...
  task automatic run_out(input int mode, input int bound);
    logic done;
    done = 1'b0;
    for (int i = 0; i < bound; i++) begin
      m_axis_tready = (mode == 1) ? ((i % 2) == 0) : 1'b1;
      @(posedge dev_clk);
      #1;
      if (exp_q.size() == 0 && m_axis_tvalid !== 1'b1) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_done", done, 1'b1);
    m_axis_tready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int log0, ws0, n;
    logic hit;
    dev_rst       = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tuser  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    repeat (2) @(posedge dev_clk);
    #1;
    check("rst_s_tready", s_axis_tready, 1'b0);
    check("rst_m_tvalid", m_axis_tvalid, 1'b0);
    check("rst_m_tlast", m_axis_tlast, 1'b0);
    check("rst_m_tdata", m_axis_tdata, 32'h0);
    check("rst_overflow", overflow_count, 16'h0);
    check("rst_frames", frame_count, 32'h0);
    check("rst_busy", busy, 1'b0);
    dev_rst = 1'b0;
    #1;
    check("post_rst_s_tready", s_axis_tready, 1'b1);

    // Single known sample, with push-to-first-word latency of two cycles.
    m_axis_tready = 1'b1;
    log0 = got_log.size();
    drive_sample(80'h1234_89ABCDEF_01234567, 32'hDEADBEEF, 7'd5, 14'd100, 1'b1, 1'b1);
    check("lat_n1_valid", m_axis_tvalid, 1'b0);
    check("lat_n1_busy", busy, 1'b1);
    @(posedge dev_clk);
    #1;
    check("lat_n2_valid", m_axis_tvalid, 1'b1);
    check("lat_n2_data", m_axis_tdata, 32'hDEADBEEF);
    run_out(0, 100);
    check("t1_count", got_log.size() - log0, 5);
    check("t1_w0", got_log[log0 + 0], {1'b0, 32'hDEADBEEF});
    check("t1_w1", got_log[log0 + 1], {1'b0, 32'hA0500064});
    check("t1_w2", got_log[log0 + 2], {1'b0, 32'h01234567});
    check("t1_w3", got_log[log0 + 3], {1'b0, 32'h89ABCDEF});
    check("t1_w4", got_log[log0 + 4], {1'b1, 32'h00001234});
    check("t1_frames", frame_count, 32'd1);
    check("t1_busy", busy, 1'b0);

    // Alternating downstream ready.
    log0 = got_log.size();
    drive_rand(1'b0, 1'b1);
    run_out(1, 200);
    check("t2_count", got_log.size() - log0, 5);

    // Fill: the first sample moves into the hold register, then 16 fill the FIFO.
    log0 = got_log.size();
    drive_rand(1'b1, 1'b1);
    repeat (3) @(posedge dev_clk);
    #1;
    check("t3_holding", m_axis_tvalid, 1'b1);
    for (int i = 0; i < 19; i++) drive_rand((i % 4) == 3, i < 16);
    check("t3_full_tready", s_axis_tready, 1'b0);
    check("t3_overflow", overflow_count, 16'd3);
    check("t3_busy", busy, 1'b1);
    run_out(0, 500);
    check("t3_count", got_log.size() - log0, 85);
    check("t3_frames", frame_count, exp_frames);

    // Two queued samples drain as ten words with no idle cycle.
    log0 = got_log.size();
    drive_rand(1'b0, 1'b1);
    drive_rand(1'b1, 1'b1);
    run_out(0, 200);
    n = hs_cyc.size();
    check("t4_count", got_log.size() - log0, 10);
    check("t4_no_bubble", hs_cyc[n - 1] - hs_cyc[n - 10], 9);
    check("t4_frames", frame_count, exp_frames);

    // Reset right after the w2 handshake.
    ws0 = words_seen;
    m_axis_tready = 1'b1;
    drive_rand(1'b1, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge dev_clk);
      #1;
      if (words_seen >= ws0 + 3) begin
        hit = 1'b1;
        break;
      end
    end
    check("t5_reached_w2", hit, 1'b1);
    m_axis_tready = 1'b0;
    dev_rst = 1'b1;
    exp_q.delete();
    words_seen = 0;
    exp_frames = 0;
    #1;
    check("t5_rst_tready", s_axis_tready, 1'b0);
    @(posedge dev_clk);
    #1;
    dev_rst = 1'b0;
    check("t5_valid", m_axis_tvalid, 1'b0);
    check("t5_overflow", overflow_count, 16'h0);
    check("t5_frames", frame_count, 32'h0);
    check("t5_busy", busy, 1'b0);
    log0 = got_log.size();
    drive_sample(80'h0042_00000003_00000002, 32'hCAFE0001, 7'd127, 14'h3FFF, 1'b1, 1'b1);
    run_out(0, 100);
    check("t5_restart_w0", got_log[log0], {1'b0, 32'hCAFE0001});
    check("t5_restart_w1", got_log[log0 + 1], {1'b0, 32'hA7F03FFF});
    check("t5_frames_after", frame_count, exp_frames);

    // Saturating overflow counter.
    log0 = got_log.size();
    drive_rand(1'b0, 1'b1);
    repeat (3) @(posedge dev_clk);
    #1;
    for (int i = 0; i < 16; i++) drive_rand(1'b1, 1'b1);
    s_axis_tdata  = {16'($urandom), $urandom, $urandom};
    s_axis_tvalid = 1'b1;
    repeat (65540) @(posedge dev_clk);
    #1;
    check("t6_saturated", overflow_count, 16'hFFFF);
    repeat (4) @(posedge dev_clk);
    #1;
    s_axis_tvalid = 1'b0;
    check("t6_holds", overflow_count, 16'hFFFF);
    run_out(0, 500);
    check("t6_count", got_log.size() - log0, 85);
    check("t6_frames", frame_count, exp_frames);
    check("t6_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
